// File: rtl/yuv420_frame_ctrl_pkg.sv
// Shared definitions for the yuv420 frame sequencer: stream word type codes
// (mirroring the packer's DTYPE_* set) and the sequencer state encoding.
package yuv420_frame_ctrl_pkg;

  localparam int DTYPE_WIDTH = 3;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 3'd0;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 3'd1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 3'd2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_START  = 3'd3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_END    = 3'd4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 3'd5;

  typedef enum logic [1:0] {
    YFC_IDLE    = 2'd0,
    YFC_WAIT_FS = 2'd1,
    YFC_PASS    = 2'd2,
    YFC_SKIP    = 2'd3
  } yfc_state_e;

  typedef struct packed {
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [15:0]            meta;
    logic [7:0]             y;
    logic [7:0]             u;
    logic [7:0]             v;
  } yfc_word_t;

endpackage

// File: rtl/yuv420_frame_ctrl.sv
// Frame-boundary gate and config shadow in front of the yuv420 packer.
// Optional skipped-frame statistics are built when YUV420_FRAME_CTRL_STATS_EN is defined.
module yuv420_frame_ctrl
  import yuv420_frame_ctrl_pkg::*;
#(
  parameter int MAX_FRAMES_W = 16,
  parameter int SKIP_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             cfg_image_type,
  input  logic                    cfg_enable,
  input  logic [SKIP_W-1:0]       cfg_skip,
  input  logic [MAX_FRAMES_W-1:0] cfg_num_frames,
  input  logic                    dvi,
  input  logic [DTYPE_WIDTH-1:0]  dtypei,
  input  logic [15:0]             meta_datai,
  input  logic [7:0]              yi,
  input  logic [7:0]              ui,
  input  logic [7:0]              vi,
  output logic                    dvo,
  output logic [DTYPE_WIDTH-1:0]  dtypeo,
  output logic [15:0]             meta_datao,
  output logic [7:0]              yo,
  output logic [7:0]              uo,
  output logic [7:0]              vo,
  output logic [15:0]             image_type,
  output logic                    enable,
  output logic                    busy,
  output logic [MAX_FRAMES_W-1:0] frame_count,
  output logic [MAX_FRAMES_W-1:0] frames_skipped
);

  localparam logic [MAX_FRAMES_W-1:0] FC_ONE  = {{(MAX_FRAMES_W-1){1'b0}}, 1'b1};
  localparam logic [MAX_FRAMES_W-1:0] FC_MAX  = {MAX_FRAMES_W{1'b1}};
  localparam logic [MAX_FRAMES_W-1:0] FC_ZERO = {MAX_FRAMES_W{1'b0}};
  localparam logic [SKIP_W-1:0]       SK_ONE  = {{(SKIP_W-1){1'b0}}, 1'b1};
  localparam logic [SKIP_W-1:0]       SK_ZERO = {SKIP_W{1'b0}};

  yfc_state_e              state_q, state_d;
  logic [SKIP_W-1:0]       skip_cnt_q, skip_cnt_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [MAX_FRAMES_W-1:0] frame_count_q, frame_count_d;
  yfc_word_t               word_q, word_d;
  logic                    dvo_q, dvo_d;
  logic [15:0]             image_type_q, image_type_d;
  logic                    enable_q, enable_d;
  logic                    busy_q;

  yfc_word_t               in_word_s;
  logic                    is_fs_s;
  logic                    is_fe_s;
  logic [MAX_FRAMES_W-1:0] fc_inc_s;
  logic                    limit_hit_s;

  assign in_word_s   = '{dtype: dtypei, meta: meta_datai, y: yi, u: ui, v: vi};
  assign is_fs_s     = dvi && (dtypei == DTYPE_FRAME_START);
  assign is_fe_s     = dvi && (dtypei == DTYPE_FRAME_END);
  assign fc_inc_s    = (frame_count_q == FC_MAX) ? frame_count_q : frame_count_q + FC_ONE;
  assign limit_hit_s = (cfg_num_frames != FC_ZERO) && (fc_inc_s == cfg_num_frames);

  // Next-state, gating and shadow-config decisions
  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    stop_pend_d   = stop_pend_q;
    frame_count_d = frame_count_q;
    word_d        = word_q;
    dvo_d         = 1'b0;
    image_type_d  = image_type_q;
    enable_d      = enable_q;

    case (state_q)
      YFC_IDLE: begin
        if (start && !stop) begin
          state_d       = YFC_WAIT_FS;
          skip_cnt_d    = SK_ZERO;
          stop_pend_d   = 1'b0;
          frame_count_d = FC_ZERO;
        end else begin
          state_d = YFC_IDLE;
        end
      end

      YFC_WAIT_FS: begin
        if (stop) begin
          state_d = YFC_IDLE;
        end else if (is_fs_s) begin
          if (skip_cnt_q == SK_ZERO) begin
            state_d      = YFC_PASS;
            image_type_d = cfg_image_type;
            enable_d     = cfg_enable;
            dvo_d        = 1'b1;
            word_d       = in_word_s;
          end else begin
            state_d    = YFC_SKIP;
            skip_cnt_d = skip_cnt_q - SK_ONE;
          end
        end else begin
          state_d = YFC_WAIT_FS;
        end
      end

      YFC_PASS: begin
        if (dvi) begin
          dvo_d  = 1'b1;
          word_d = in_word_s;
        end else begin
          dvo_d = 1'b0;
        end
        // A stop arriving together with FRAME_END still ends capture at this boundary
        if (is_fe_s) begin
          frame_count_d = fc_inc_s;
          skip_cnt_d    = cfg_skip;
          stop_pend_d   = 1'b0;
          if (stop_pend_q || stop || limit_hit_s) begin
            state_d = YFC_IDLE;
          end else begin
            state_d = YFC_WAIT_FS;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
      end

      YFC_SKIP: begin
        if (stop) begin
          state_d = YFC_IDLE;
        end else if (is_fe_s) begin
          state_d = YFC_WAIT_FS;
        end else begin
          state_d = YFC_SKIP;
        end
      end

      default: begin
        state_d = YFC_IDLE;
      end
    endcase
  end

  // State, counters and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= YFC_IDLE;
      skip_cnt_q    <= SK_ZERO;
      stop_pend_q   <= 1'b0;
      frame_count_q <= FC_ZERO;
      word_q        <= '0;
      dvo_q         <= 1'b0;
      image_type_q  <= 16'h0000;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      stop_pend_q   <= stop_pend_d;
      frame_count_q <= frame_count_d;
      word_q        <= word_d;
      dvo_q         <= dvo_d;
      image_type_q  <= image_type_d;
      enable_q      <= enable_d;
      busy_q        <= (state_q != YFC_IDLE);
    end
  end

`ifdef YUV420_FRAME_CTRL_STATS_EN
  logic [MAX_FRAMES_W-1:0] frames_skipped_q;
  logic                    skip_evt_s;
  logic                    stats_clr_s;

  assign skip_evt_s  = (state_q == YFC_WAIT_FS) && !stop && is_fs_s && (skip_cnt_q != SK_ZERO);
  assign stats_clr_s = (state_q == YFC_IDLE) && start && !stop;

  // Saturating count of frames dropped by decimation
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_skipped_q <= FC_ZERO;
    end else if (stats_clr_s) begin
      frames_skipped_q <= FC_ZERO;
    end else if (skip_evt_s && (frames_skipped_q != FC_MAX)) begin
      frames_skipped_q <= frames_skipped_q + FC_ONE;
    end else begin
      frames_skipped_q <= frames_skipped_q;
    end
  end

  assign frames_skipped = frames_skipped_q;
`else
  assign frames_skipped = FC_ZERO;
`endif

  assign dvo         = dvo_q;
  assign dtypeo      = word_q.dtype;
  assign meta_datao  = word_q.meta;
  assign yo          = word_q.y;
  assign uo          = word_q.u;
  assign vo          = word_q.v;
  assign image_type  = image_type_q;
  assign enable      = enable_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_yuv420_frame_ctrl.sv
// Scoreboard bench for yuv420_frame_ctrl: stimulus pushes expected forwarded words,
// a negedge monitor pops and compares every word the DUT presents.
module tb_yuv420_frame_ctrl;
  import yuv420_frame_ctrl_pkg::*;

  localparam int MFW = 16;
  localparam int SW  = 8;
`ifdef YUV420_FRAME_CTRL_STATS_EN
  localparam logic [15:0] EXP_SKIPPED = 16'd4;
`else
  localparam logic [15:0] EXP_SKIPPED = 16'd0;
`endif

  logic                   clk = 1'b0;
  logic                   reset, start, stop;
  logic [15:0]            cfg_image_type;
  logic                   cfg_enable;
  logic [SW-1:0]          cfg_skip;
  logic [MFW-1:0]         cfg_num_frames;
  logic                   dvi;
  logic [DTYPE_WIDTH-1:0] dtypei;
  logic [15:0]            meta_datai;
  logic [7:0]             yi, ui, vi;
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0]            meta_datao;
  logic [7:0]             yo, uo, vo;
  logic [15:0]            image_type;
  logic                   enable, busy;
  logic [MFW-1:0]         frame_count, frames_skipped;

  yuv420_frame_ctrl #(.MAX_FRAMES_W(MFW), .SKIP_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_image_type(cfg_image_type), .cfg_enable(cfg_enable),
    .cfg_skip(cfg_skip), .cfg_num_frames(cfg_num_frames),
    .dvi(dvi), .dtypei(dtypei), .meta_datai(meta_datai), .yi(yi), .ui(ui), .vi(vi),
    .dvo(dvo), .dtypeo(dtypeo), .meta_datao(meta_datao), .yo(yo), .uo(uo), .vo(vo),
    .image_type(image_type), .enable(enable), .busy(busy),
    .frame_count(frame_count), .frames_skipped(frames_skipped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  dt;
    logic [15:0] meta;
    logic [7:0]  y;
    logic [7:0]  u;
    logic [7:0]  v;
    logic [15:0] it;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  exp_t mon_e;
  int   mon_c;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the head of the scoreboard
  always @(negedge clk) begin
    if (dvo === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got dtype %0h meta %0h y %0h, expected no output",
                 dtypeo, meta_datao, yo);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        chk("fwd_word", {4'h0, dtypeo, meta_datao, yo, uo, vo, image_type, enable}, {4'h0, mon_e});
        chk("fwd_latency", 64'(cyc_cnt), 64'(mon_c));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] wtype(input int idx);
    case (idx)
      0:       return DTYPE_FRAME_START;
      1, 7:    return DTYPE_LINE_START;
      6, 12:   return DTYPE_LINE_END;
      13:      return DTYPE_FRAME_END;
      default: return DTYPE_PIXEL;
    endcase
  endfunction

  // Frame of 4x2 pixels: FS, (LS, 4 px, LE) x2, FE = 14 words
  task automatic send_frame(input int fid, input bit fwd, input logic [15:0] it, input logic en,
                            input int nwords = 14, input int stop_at = -1, input int cfg_at = -1,
                            input logic [15:0] new_it = 16'h0, input logic new_en = 1'b0);
    exp_t e;
    for (int i = 0; i < nwords; i++) begin
      if (i == cfg_at) begin
        cfg_image_type = new_it;
        cfg_enable     = new_en;
      end
      stop       = (i == stop_at);
      dvi        = 1'b1;
      dtypei     = wtype(i);
      meta_datai = {fid[7:0], i[7:0]};
      yi         = 8'(fid * 16 + i);
      ui         = ~yi;
      vi         = yi ^ 8'h5A;
      if (fwd) begin
        e = '{dt: dtypei, meta: meta_datai, y: yi, u: ui, v: vi, it: it, en: en};
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc_cnt + 1);
      end
      cyc();
    end
    stop = 1'b0;
    dvi  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dvo"}, 64'(dvo), 64'd0);
    chk({tag, "_dtypeo"}, 64'(dtypeo), 64'd0);
    chk({tag, "_meta"}, 64'(meta_datao), 64'd0);
    chk({tag, "_yuv"}, 64'({yo, uo, vo}), 64'd0);
    chk({tag, "_image_type"}, 64'(image_type), 64'd0);
    chk({tag, "_enable"}, 64'(enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    chk({tag, "_frames_skipped"}, 64'(frames_skipped), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_image_type = 16'h0; cfg_enable = 1'b0; cfg_skip = 8'd0; cfg_num_frames = 16'd0;
    dvi = 1'b0; dtypei = 3'd0; meta_datai = 16'h0; yi = 8'h0; ui = 8'h0; vi = 8'h0;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    reset = 1'b0;
    cyc();

    // Continuous capture, then stop while waiting for a frame start
    cfg_image_type = 16'h0011; cfg_enable = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) send_frame(f, 1'b1, 16'h0011, 1'b1);
    cyc();
    chk("cont_frame_count", 64'(frame_count), 64'd3);
    chk("cont_busy", 64'(busy), 64'd1);
    pulse_stop();
    cyc();
    chk("stop_wait_busy", 64'(busy), 64'd0);
    send_frame(3, 1'b0, 16'h0, 1'b0);

    // Decimation by 3: frames 0, 3, 6 pass
    cfg_skip = 8'd2; cfg_image_type = 16'h0022; cfg_enable = 1'b0;
    pulse_start();
    for (int f = 0; f < 7; f++) send_frame(10 + f, (f % 3) == 0, 16'h0022, 1'b0);
    cyc();
    chk("dec_frame_count", 64'(frame_count), 64'd3);
    chk("dec_frames_skipped", 64'(frames_skipped), 64'(EXP_SKIPPED));
    pulse_stop();
    cfg_skip = 8'd0;
    cyc();

    // N-frame capture of 2
    cfg_num_frames = 16'd2; cfg_image_type = 16'h0033; cfg_enable = 1'b1;
    pulse_start();
    send_frame(20, 1'b1, 16'h0033, 1'b1);
    send_frame(21, 1'b1, 16'h0033, 1'b1);
    chk("nfr_busy_at_fe", 64'(busy), 64'd1);
    cyc();
    chk("nfr_busy_after", 64'(busy), 64'd0);
    chk("nfr_frame_count", 64'(frame_count), 64'd2);
    send_frame(22, 1'b0, 16'h0, 1'b0);
    cfg_num_frames = 16'd0;

    // Stop at the 5th pixel: frame completes, then idle
    cfg_image_type = 16'h0044;
    pulse_start();
    send_frame(30, 1'b1, 16'h0044, 1'b1, 14, 8);
    cyc();
    chk("stop_pass_busy", 64'(busy), 64'd0);
    chk("stop_pass_frame_count", 64'(frame_count), 64'd1);
    send_frame(31, 1'b0, 16'h0, 1'b0);

    // Config shadowing across a mid-frame change
    cfg_image_type = 16'h0001; cfg_enable = 1'b1;
    pulse_start();
    send_frame(40, 1'b1, 16'h0001, 1'b1, 14, -1, 5, 16'h0000, 1'b0);
    chk("shadow_hold_it", 64'(image_type), 64'd1);
    chk("shadow_hold_en", 64'(enable), 64'd1);
    send_frame(41, 1'b1, 16'h0000, 1'b0);
    chk("shadow_new_it", 64'(image_type), 64'd0);
    pulse_stop();
    cyc();

    // start and stop together from idle: no arm
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    cyc();
    chk("start_stop_busy", 64'(busy), 64'd0);
    send_frame(50, 1'b0, 16'h0, 1'b0);

    // Reset in the middle of a passed frame
    cfg_image_type = 16'h00A5; cfg_enable = 1'b1;
    pulse_start();
    send_frame(60, 1'b1, 16'h00A5, 1'b1, 6);
    reset = 1'b1; dvi = 1'b1; dtypei = DTYPE_PIXEL; yi = 8'h77;
    cyc();
    reset = 1'b0; dvi = 1'b0;
    chk_reset_outputs("midreset");

    repeat (3) cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
